// File: rtl/stg_pkg.sv
// Shared stage definitions: player hit-controller state encoding and the
// lives/iframe defaults also consumed by the HUD.
package stg_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_HIT       = 2'd1,
        ST_INVULN    = 2'd2,
        ST_GAME_OVER = 2'd3
    } player_state_e;

    localparam int unsigned LIVES_W            = 3;
    localparam int unsigned FRAME_CNT_W        = 8;
    localparam int unsigned IFRAME_W           = 8;
    localparam int unsigned LIVES_INIT_DEFAULT = 3;
    localparam int unsigned IFRAMES_DEFAULT    = 120;

endpackage

// File: rtl/frame_overlap_latch.sv
// Accumulates player/enemy pixel overlap across a frame; overlap_eval is the
// frame's verdict, valid in the frame_tick cycle (includes that cycle's pixel).
module frame_overlap_latch (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic video_on,
    input  logic player_on,
    input  logic enemy_on,
    input  logic bullet_on,
    output logic overlap_eval
);

    logic overlap_now;
    logic overlap_flag_q, overlap_flag_d;

    always_comb begin
        overlap_now    = video_on & player_on & (enemy_on | bullet_on);
        overlap_eval   = overlap_flag_q | overlap_now;
        overlap_flag_d = frame_tick ? 1'b0 : overlap_eval;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overlap_flag_q <= 1'b0;
        end else begin
            overlap_flag_q <= overlap_flag_d;
        end
    end

endmodule

// File: rtl/player_hit_ctrl.sv
// Player hit resolution: lives, invincibility frames, blink and game-over.
// PLAYER_GOD_MODE_EN: hits still register but never cost a life.
module player_hit_ctrl
    import stg_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = LIVES_INIT_DEFAULT,
    parameter int unsigned IFRAMES     = IFRAMES_DEFAULT,
    parameter int unsigned BLINK_SHIFT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               video_on,
    input  logic               player_on,
    input  logic               enemy_on,
    input  logic               bullet_on,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               hit_pulse,
    output logic               invincible,
    output logic               player_visible,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0]  LIVES_RST  = LIVES_W'(LIVES_INIT);
    localparam logic [IFRAME_W-1:0] IFRAMES_LD = IFRAME_W'(IFRAMES);

    player_state_e          state_q, state_d;
    logic [LIVES_W-1:0]     lives_q, lives_d;
    logic [IFRAME_W-1:0]    iframe_cnt_q, iframe_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   overlap_eval;

    frame_overlap_latch u_overlap (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .video_on     (video_on),
        .player_on    (player_on),
        .enemy_on     (enemy_on),
        .bullet_on    (bullet_on),
        .overlap_eval (overlap_eval)
    );

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        iframe_cnt_d = iframe_cnt_q;
        frame_cnt_d  = frame_cnt_q + {{(FRAME_CNT_W-1){1'b0}}, frame_tick};

        case (state_q)
            ST_ALIVE: begin
                if (frame_tick && overlap_eval) state_d = ST_HIT;
            end
            ST_HIT: begin
`ifdef PLAYER_GOD_MODE_EN
                iframe_cnt_d = IFRAMES_LD;
                state_d      = ST_INVULN;
`else
                if (lives_q <= LIVES_W'(1)) begin
                    lives_d = '0;
                    state_d = ST_GAME_OVER;
                end else begin
                    lives_d      = lives_q - LIVES_W'(1);
                    iframe_cnt_d = IFRAMES_LD;
                    state_d      = ST_INVULN;
                end
`endif
            end
            ST_INVULN: begin
                // Leaving on the last tick skips that frame's overlap verdict.
                if (frame_tick) begin
                    iframe_cnt_d = iframe_cnt_q - IFRAME_W'(1);
                    if (iframe_cnt_q <= IFRAME_W'(1)) state_d = ST_ALIVE;
                end
            end
            ST_GAME_OVER: begin
                if (restart) begin
                    state_d      = ST_ALIVE;
                    lives_d      = LIVES_RST;
                    iframe_cnt_d = '0;
                end
            end
            default: state_d = ST_ALIVE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ALIVE;
            lives_q      <= LIVES_RST;
            iframe_cnt_q <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            iframe_cnt_q <= iframe_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        lives          = lives_q;
        hit_pulse      = (state_q == ST_HIT);
        invincible     = (state_q == ST_INVULN);
        game_over      = (state_q == ST_GAME_OVER);
        player_visible = !game_over && (!invincible || !frame_cnt_q[BLINK_SHIFT]);
    end

endmodule

// File: tb/tb_player_hit_ctrl.sv
// Randomised/directed bench for player_hit_ctrl against a frame-level model
// that tracks lives, remaining invulnerable frames and a pending hit.
module tb_player_hit_ctrl;

    localparam int unsigned LI = 3;
    localparam int unsigned IF = 120;
    localparam int unsigned BS = 3;
`ifdef PLAYER_GOD_MODE_EN
    localparam bit GOD = 1'b1;
`else
    localparam bit GOD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, frame_tick, video_on, player_on, enemy_on, bullet_on, restart;
    logic [2:0] lives;
    logic       hit_pulse, invincible, player_visible, game_over;
    logic [6:0] obs;

    player_hit_ctrl #(.LIVES_INIT(LI), .IFRAMES(IF), .BLINK_SHIFT(BS)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .video_on       (video_on),
        .player_on      (player_on),
        .enemy_on       (enemy_on),
        .bullet_on      (bullet_on),
        .restart        (restart),
        .lives          (lives),
        .hit_pulse      (hit_pulse),
        .invincible     (invincible),
        .player_visible (player_visible),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;
    assign obs = {lives, hit_pulse, invincible, player_visible, game_over};

    int tests = 0;
    int fails = 0;

    // Model: lives, frames of invulnerability left, hit pending, dead, frame count.
    int m_lives, m_inv, m_frames;
    bit m_hit, m_dead, m_ov;

    function automatic void model_reset();
        m_lives = LI; m_inv = 0; m_frames = 0;
        m_hit = 0; m_dead = 0; m_ov = 0;
    endfunction

    function automatic void model_step();
        bit ov_frame = m_ov || (video_on && player_on && (enemy_on || bullet_on));
        if (m_hit) begin
            m_hit = 0;
            if (!GOD && m_lives == 1) begin
                m_lives = 0;
                m_dead  = 1;
            end else begin
                if (!GOD) m_lives = m_lives - 1;
                m_inv = IF;
            end
        end else if (m_dead) begin
            if (restart) begin
                m_dead = 0; m_lives = LI; m_inv = 0;
            end
        end else if (frame_tick) begin
            if (m_inv > 0) m_inv = m_inv - 1;
            else if (ov_frame) m_hit = 1;
        end
        if (frame_tick) m_frames = (m_frames + 1) % 256;
        m_ov = frame_tick ? 1'b0 : ov_frame;
    endfunction

    function automatic logic [6:0] model_out();
        bit inv = (m_inv > 0);
        bit vis = !m_dead && (!inv || ((m_frames >> BS) & 1) == 0);
        return {3'(m_lives), m_hit, inv, vis, m_dead};
    endfunction

    task automatic do_cycle(input bit vid, input bit pl, input bit en, input bit bu,
                            input bit tk, input bit rs);
        video_on = vid; player_on = pl; enemy_on = en; bullet_on = bu;
        frame_tick = tk; restart = rs;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        video_on = 0; player_on = 0; enemy_on = 0; bullet_on = 0; frame_tick = 0; restart = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (obs !== {3'(LI), 1'b0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got %b want %b", obs, {3'(LI), 4'b0010});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_first_hit();
        for (int unsigned c = 0; c < 6; c++) begin
            do_cycle(1'b1, c == 2, c == 2, 1'b0, c == 5, 1'b0);
            tests++;
            if (obs !== model_out()) begin
                fails++;
                $display("FAIL first_hit c%0d: got %b want %b", c, obs, model_out());
            end
        end
        tests++;
        if (hit_pulse !== 1'b1) begin
            fails++;
            $display("FAIL first_hit_pulse: got %b want 1", hit_pulse);
        end
        for (int unsigned c = 0; c < 2; c++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tests++;
            if (obs !== model_out()) begin
                fails++;
                $display("FAIL first_hit_after c%0d: got %b want %b", c, obs, model_out());
            end
        end
    endtask

    task automatic test_iframes();
        int pulses = 0;
        for (int unsigned f = 0; f < IF; f++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                do_cycle(1'b1, 1'b1, c == 1, c == 2, c == 3, 1'b0);
                if (hit_pulse === 1'b1) pulses++;
                tests++;
                if (obs !== model_out()) begin
                    fails++;
                    $display("FAIL iframes f%0d c%0d: got %b want %b", f, c, obs, model_out());
                end
            end
        end
        tests++;
        if (pulses != 0 || invincible !== 1'b0) begin
            fails++;
            $display("FAIL iframes_ignore: got pulses=%0d inv=%b want pulses=0 inv=0", pulses, invincible);
        end
        for (int unsigned c = 0; c < 6; c++) begin
            do_cycle(1'b1, c == 1, 1'b0, c == 1, c == 3, 1'b0);
            tests++;
            if (obs !== model_out()) begin
                fails++;
                $display("FAIL rehit c%0d: got %b want %b", c, obs, model_out());
            end
        end
    endtask

    task automatic test_game_over();
        for (int unsigned f = 0; f < IF + 2; f++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                do_cycle(1'b1, 1'b0, 1'b0, 1'b0, c == 2, 1'b0);
                tests++;
                if (obs !== model_out()) begin
                    fails++;
                    $display("FAIL go_wait f%0d c%0d: got %b want %b", f, c, obs, model_out());
                end
            end
        end
        // Final hit, then ticks while dead, then restart.
        for (int unsigned c = 0; c < 16; c++) begin
            do_cycle(1'b1, c == 0, c == 0, 1'b0, (c % 4) == 1, c == 13);
            tests++;
            if (obs !== model_out()) begin
                fails++;
                $display("FAIL game_over c%0d: got %b want %b", c, obs, model_out());
            end
        end
    endtask

    task automatic test_tick_overlap();
        int pulses = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            do_cycle(1'b1, c == 3, c == 3, 1'b0, c == 3, 1'b0);
            if (hit_pulse === 1'b1) pulses++;
            tests++;
            if (obs !== model_out()) begin
                fails++;
                $display("FAIL tick_overlap c%0d: got %b want %b", c, obs, model_out());
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL tick_overlap_pulses: got %0d want 1", pulses);
        end
        for (int unsigned f = 0; f < IF + 1; f++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                do_cycle(1'b1, 1'b0, 1'b0, 1'b0, c == 2, 1'b0);
                tests++;
                if (obs !== model_out()) begin
                    fails++;
                    $display("FAIL tick_wait f%0d c%0d: got %b want %b", f, c, obs, model_out());
                end
            end
        end
        pulses = 0;
        for (int unsigned c = 0; c < 7; c++) begin
            do_cycle(1'b0, 1'b1, 1'b1, 1'b1, c == 4, 1'b0);
            if (hit_pulse === 1'b1) pulses++;
            tests++;
            if (obs !== model_out()) begin
                fails++;
                $display("FAIL video_off c%0d: got %b want %b", c, obs, model_out());
            end
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL video_off_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_blink_reset();
        bit seen_vis0 = 0;
        bit seen_vis1 = 0;
        for (int unsigned f = 0; f < 40; f++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                do_cycle(1'b1, f == 0, f == 0, 1'b0, c == 2, 1'b0);
                if (invincible === 1'b1 && player_visible === 1'b0) seen_vis0 = 1;
                if (invincible === 1'b1 && player_visible === 1'b1) seen_vis1 = 1;
                tests++;
                if (obs !== model_out()) begin
                    fails++;
                    $display("FAIL blink f%0d c%0d: got %b want %b", f, c, obs, model_out());
                end
            end
        end
        tests++;
        if (!(seen_vis0 && seen_vis1)) begin
            fails++;
            $display("FAIL blink_toggle: got vis0=%b vis1=%b want both 1", seen_vis0, seen_vis1);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        tests++;
        if (obs !== model_out() || invincible !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got %b want %b", obs, model_out());
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        int unsigned left = 0;
        for (int unsigned i = 0; i < 2500; i++) begin
            bit tk;
            if (left == 0) left = $urandom_range(2, 8);
            left--;
            tk = (left == 0);
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     tk, $urandom_range(0, 15) == 0);
            tests++;
            if (obs !== model_out()) begin
                fails++;
                $display("FAIL random i%0d: got %b want %b", i, obs, model_out());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_hit();
        test_iframes();
        test_game_over();
        test_tick_overlap();
        test_blink_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/player_hit_ctrl.md
Name: player_hit_ctrl

Overview:
- Sits downstream of the enemy sprite blocks (moon, bullets) and the player sprite, in parallel with the final VGA pixel mux.
- Watches per-pixel overlap of the player mask with enemy/bullet masks during each frame, and resolves a hit once per frame at frame_tick.
- Manages lives, invincibility frames, player blink and game-over.
- Its outputs feed the player sprite (visibility), the HUD (lives) and the top-level game FSM (game_over).

Parameters:
- LIVES_INIT, 3, lives loaded at reset/restart (1..7).
- IFRAMES, 120, invincibility duration in frames after a hit (1..255).
- BLINK_SHIFT, 3, player blinks with period 2^(BLINK_SHIFT+1) frames while invincible.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- video_on  in  1  pixel (x,y) is in active area
- player_on  in  1  player sprite mask at current pixel
- enemy_on  in  1  enemy mask (moon_on) at current pixel
- bullet_on  in  1  enemy bullet mask at current pixel
- restart  in  1  level-sampled; leaves GAME_OVER
- lives  out  3  remaining lives
- hit_pulse  out  1  one-cycle pulse when a hit is accepted
- invincible  out  1  high while iframe counter nonzero
- player_visible  out  1  gate for player sprite drawing
- game_over  out  1  high in GAME_OVER state

Behaviour:
- Reset is asynchronous and active-high; the clock is clk. Reset values: lives=LIVES_INIT, hit_pulse=0, invincible=0, player_visible=1, game_over=0, state=ALIVE, overlap_flag=0, iframe_cnt=0, frame_cnt=0.
- Overlap capture: overlap_flag is set on any cycle with video_on & player_on & (enemy_on | bullet_on). It clears on the cycle after frame_tick.
  - An overlap coinciding with frame_tick belongs to the frame being closed: it is OR'd into the evaluated value.
- States: ALIVE, HIT, INVULN, GAME_OVER (2-bit encoding).
- ALIVE: at frame_tick with the evaluated overlap=1 -> HIT. Otherwise stay.
- HIT: lasts exactly one cycle, with hit_pulse=1 in that cycle.
  - If lives==1: lives<=0 and next state is GAME_OVER.
  - Otherwise: lives<=lives-1, iframe_cnt<=IFRAMES, next state is INVULN.
  - Latency: hit_pulse asserts 1 cycle after the frame_tick cycle.
- INVULN: overlap is ignored (the flag still captures but is discarded).
  - Each frame_tick decrements iframe_cnt.
  - When iframe_cnt reaches 0 at a frame_tick -> ALIVE. The overlap of that same frame is not evaluated, so there is no immediate re-hit.
- GAME_OVER: game_over=1, player_visible=0, frame_tick ignored.
  - restart=1 -> ALIVE with lives=LIVES_INIT and iframe_cnt=0, next cycle.
- restart in ALIVE/HIT/INVULN is ignored.
- invincible = (state==INVULN).
- frame_cnt is a free-running 8-bit count incremented on frame_tick; it wraps 255->0.
- player_visible = !game_over & (!invincible | !frame_cnt[BLINK_SHIFT]).
- lives never underflows: decrement happens only when lives>=2; lives==1 goes to 0 via the GAME_OVER path.
- A reset asserted mid-INVULN or mid-GAME_OVER returns everything to reset values immediately.

Optional Feature:
- Macro: PLAYER_GOD_MODE_EN.
- Defined: hits are still detected and hit_pulse/INVULN/blink behave normally, but lives is never decremented and GAME_OVER is unreachable. Lives==1 takes the INVULN path.
- Undefined: behaviour exactly as above.

Decomposition:
- Shared package stg_pkg holds:
  - the state encoding typedef (ALIVE/HIT/INVULN/GAME_OVER);
  - LIVES_W=3 and FRAME_CNT_W=8;
  - the default LIVES_INIT and IFRAMES constants, also used by the HUD.
- One natural sub-module, frame_overlap_latch: captures the per-frame overlap flag and produces the evaluated value at frame_tick.
- The FSM, counters and blink logic live in player_hit_ctrl.

Test Plan:
- Overlap pixel (player_on=enemy_on=video_on=1) mid-frame, then frame_tick -> hit_pulse one cycle later, lives 3->2, invincible=1, iframe_cnt=120.
- Overlap in every frame during INVULN -> no hit_pulse for 120 frame_ticks. The frame after invincible drops, a new overlap gives lives 2->1.
- lives=1 plus overlap -> hit_pulse, lives=0, game_over=1, player_visible=0. frame_ticks are then ignored; restart=1 gives lives=3 and ALIVE next cycle.
- Overlap only on the same cycle as frame_tick -> counted for that frame (hit). Overlap only with video_on=0 -> no hit.
- While invincible, check player_visible toggles every 8 frames per frame_cnt[3]. Assert reset mid-INVULN -> all outputs return to reset values asynchronously.
- With PLAYER_GOD_MODE_EN defined: 5 spaced hits -> 5 hit_pulses, lives stays 3, game_over stays 0.
